as_uart: RTL and testbench
==========================

Name: as_uart

Overview:
- Full-duplex 8N1 UART peripheral: one transmitter and one receiver sharing a single clock.
- Parallel side: a start/ready handshake for TX and a ready flag plus data register for RX.
- Serial side: rx_i and tx_o pins at a fixed baud rate derived from the system clock.
- Sits between the core's memory-mapped I/O logic and the board UART pins.

Parameters:
- CLK_FREQ, 125_000_000, system clock frequency in Hz (8 ns period).
- BAUD_RATE, 9600, serial bit rate.
- BIT_CNT, CLK_FREQ/BAUD_RATE (13020), clocks per bit, integer division.
- Data width is the shared package constant uart_width (8); it is not a parameter.

Ports:
- clk_i, in, 1: system clock, rising edge.
- rst_i, in, 1: asynchronous, active-high reset.
- rx_i, in, 1: serial input; asynchronous to clk_i; idles high.
- tx_o, out, 1: serial output; idles high.
- start_i, in, 1: TX start request, sampled on the clock edge.
- data_i, in, uart_width: byte to transmit, captured when start is accepted.
- data_o, out, uart_width: last correctly received byte.
- rdy_rx_o, out, 1: a received byte is available in data_o.
- rdy_tx_o, out, 1: transmitter idle; start_i is accepted.

Behaviour:
- Reset values: tx_o=1, rdy_tx_o=1, rdy_rx_o=0, data_o=0. All state machines go to IDLE and all counters clear. Reset mid-frame aborts the frame immediately.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity. Each bit lasts BIT_CNT clocks.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: start_i=1 at a clock edge latches data_i into a shift register and moves to START.
  - START: on that same edge tx_o goes 0 and rdy_tx_o goes 0.
  - DATA: after BIT_CNT clocks, enters DATA and shifts out bits 0..7, each held BIT_CNT clocks.
  - STOP: tx_o=1 for BIT_CNT clocks, then return to IDLE with rdy_tx_o=1.
  - Total busy time is 10*BIT_CNT clocks.
  - start_i is ignored while rdy_tx_o=0; a held start_i starts a new frame on the first IDLE edge.
  - data_i changes after acceptance have no effect.
- RX input conditioning: rx_i passes through a 2-flop synchronizer. All RX logic uses the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on a synchronized falling level (rx=0).
  - START: wait BIT_CNT/2 clocks, then re-sample. If rx=1 (glitch), return to IDLE; otherwise go to DATA.
  - DATA: sample 8 bits, each BIT_CNT clocks after the previous sample (mid-bit), shifting in LSB first.
  - STOP: sample the stop bit at mid-bit.
    - Stop=1: load the shift register into data_o, set rdy_rx_o=1, go to IDLE.
    - Stop=0 (framing error): discard the byte; data_o and rdy_rx_o are unchanged; wait in STOP until rx=1, then go to IDLE.
- rdy_rx_o is a level. It stays 1 until the next start bit is confirmed (mid-start sample), then clears to 0. data_o holds its value until the next valid frame overwrites it.
- TX and RX are fully independent. Simultaneous operation is required; there are no shared counters.

Decomposition:
- Shared package as_pack holds uart_width=8. Add the typedef uart_state_t (IDLE, START, DATA, STOP), shared by both FSMs.
- Sub-module as_uart_rx holds the synchronizer, RX FSM, sampling counter and data register.
- The transmitter and the port glue stay in as_uart.

Test Plan:
- Reset: rst_i=1 for 10 clocks → tx_o=1, rdy_tx_o=1, rdy_rx_o=0, data_o=0x00.
- TX 0x55: data_i=0x55, one-clock start_i pulse.
  - rdy_tx_o falls on the next edge.
  - tx_o sequence is 0,1,0,1,0,1,0,1,0,1, each bit BIT_CNT clocks (~104 µs).
  - rdy_tx_o returns to 1 after 10*BIT_CNT clocks.
- RX 0x53: drive rx_i with 0,1,1,0,0,1,0,1,0,1,1 at 104 µs per bit.
  - data_o=0x53 and rdy_rx_o=1 from the stop-bit mid-sample onward.
  - No change to tx_o.
- Glitch rejection: rx_i low for 100 clocks, then high → rdy_rx_o and data_o unchanged; receiver returns to IDLE.
- Framing error: send 0xA5 with the stop bit driven 0 → data_o keeps its previous value and rdy_rx_o is not set. A following valid 0x3C frame is received correctly.
- Busy start and duplex: assert start_i mid-transmission of 0x55 while receiving 0x53 → the busy start_i is ignored. Both transfers complete intact and the next start is accepted once rdy_tx_o=1.

Source files
------------

// File: rtl/as_uart_pkg.sv
`default_nettype none
// ============================================================================
// Package     : as_pack
// Description : Shared UART width and the state encoding used by TX and RX.
// Revision    : 1.0 - initial release
// ============================================================================
package as_pack;

    localparam int uart_width = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/as_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : as_uart_rx
// Description : 8N1 receiver with input synchronizer, mid-bit sampling,
//               glitch rejection and framing-error recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module as_uart_rx
    import as_pack::*;
#(
    parameter int BIT_CNT = 13020
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_i,
    output logic [uart_width-1:0] data_o,
    output logic                  rdy_rx_o
);

    localparam int c_cnt_w = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
    localparam int c_idx_w = $clog2(uart_width);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(BIT_CNT - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(BIT_CNT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(uart_width - 1);
    localparam logic [c_idx_w-1:0] c_idx_one   = c_idx_w'(1);

    logic [1:0]            r_sync;
    logic                  w_rx;
    uart_state_t           r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_idx_w-1:0]    r_bit_idx;
    logic [uart_width-1:0] r_shift;
    logic [uart_width-1:0] r_data;
    logic                  r_rdy;
    logic                  r_ferr;

    // Synchronizer presets to the idle level so reset release cannot fake a start bit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx_i};
        end
    end

    assign w_rx = r_sync[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_rdy     <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt <= '0;
                        if (w_rx) begin
                            r_state <= IDLE;
                        end else begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                            r_rdy     <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                DATA: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[uart_width-1:1]};
                        if (r_bit_idx == c_idx_last) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + c_idx_one;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                STOP: begin
                    // After a framing error, park here until the line is released
                    if (r_ferr) begin
                        if (w_rx) begin
                            r_ferr  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else if (r_cnt == c_bit_last) begin
                        r_cnt <= '0;
                        if (w_rx) begin
                            r_data  <= r_shift;
                            r_rdy   <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_o   = r_data;
    assign rdy_rx_o = r_rdy;

endmodule
`default_nettype wire

// File: rtl/as_uart.sv
`default_nettype none
// ============================================================================
// Module      : as_uart
// Description : Full-duplex 8N1 UART: transmitter here, receiver in as_uart_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module as_uart
    import as_pack::*;
#(
    parameter int CLK_FREQ  = 125_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int BIT_CNT   = CLK_FREQ / BAUD_RATE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_i,
    output logic                  tx_o,
    input  logic                  start_i,
    input  logic [uart_width-1:0] data_i,
    output logic [uart_width-1:0] data_o,
    output logic                  rdy_rx_o,
    output logic                  rdy_tx_o
);

    localparam int c_cnt_w = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
    localparam int c_idx_w = $clog2(uart_width);
    localparam logic [c_cnt_w-1:0] c_bit_last = c_cnt_w'(BIT_CNT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(uart_width - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

    uart_state_t           r_tx_state;
    logic [c_cnt_w-1:0]    r_tx_cnt;
    logic [c_idx_w-1:0]    r_tx_idx;
    logic [uart_width-1:0] r_tx_shift;
    logic                  r_tx;
    logic                  r_rdy_tx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
            r_rdy_tx   <= 1'b1;
        end else begin
            case (r_tx_state)
                IDLE: begin
                    r_tx_cnt <= '0;
                    // Start bit goes out on the accepting edge itself
                    if (start_i) begin
                        r_tx_shift <= data_i;
                        r_tx       <= 1'b0;
                        r_rdy_tx   <= 1'b0;
                        r_tx_state <= START;
                    end
                end
                START: begin
                    if (r_tx_cnt == c_bit_last) begin
                        r_tx_cnt   <= '0;
                        r_tx_idx   <= '0;
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_state <= DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_cnt_one;
                    end
                end
                DATA: begin
                    if (r_tx_cnt == c_bit_last) begin
                        r_tx_cnt <= '0;
                        if (r_tx_idx == c_idx_last) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= STOP;
                        end else begin
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_idx   <= r_tx_idx + c_idx_one;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_cnt_one;
                    end
                end
                STOP: begin
                    if (r_tx_cnt == c_bit_last) begin
                        r_tx_cnt   <= '0;
                        r_rdy_tx   <= 1'b1;
                        r_tx_state <= IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_cnt_one;
                    end
                end
                default: r_tx_state <= IDLE;
            endcase
        end
    end

    assign tx_o     = r_tx;
    assign rdy_tx_o = r_rdy_tx;

    as_uart_rx #(
        .BIT_CNT (BIT_CNT)
    ) u_rx (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rx_i     (rx_i),
        .data_o   (data_o),
        .rdy_rx_o (rdy_rx_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_as_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_as_uart
// Description : Self-checking bench for as_uart with a timing-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_as_uart;
    import as_pack::*;

    localparam int CLK_FREQ  = 3_200_000;
    localparam int BAUD_RATE = 100_000;
    localparam int c_bit     = CLK_FREQ / BAUD_RATE;
    localparam int c_half    = c_bit / 2;
    localparam int c_tol     = 2;

    logic       clk_i   = 1'b0;
    logic       rst_i   = 1'b1;
    logic       rx_i    = 1'b1;
    logic       start_i = 1'b0;
    logic [7:0] data_i  = 8'h00;
    logic       tx_o;
    logic [7:0] data_o;
    logic       rdy_rx_o;
    logic       rdy_tx_o;

    as_uart #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rx_i     (rx_i),
        .tx_o     (tx_o),
        .start_i  (start_i),
        .data_i   (data_i),
        .data_o   (data_o),
        .rdy_rx_o (rdy_rx_o),
        .rdy_tx_o (rdy_tx_o)
    );

    always #4 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;

    // Transmitter model: start edge of the current frame and edge when it ends
    int         m_e0 = -1;
    int         m_busy_end = -1;
    logic [7:0] m_tx_data = 8'h00;

    // Receiver model: expected outputs plus scheduled changes from the frame driver
    logic       m_rdy_rx = 1'b0;
    logic [7:0] m_data = 8'h00;
    int         m_last_ev = -1000;
    int         ev_edge[$];
    logic       ev_set[$];
    logic [7:0] ev_dat[$];

    int   e_chk;
    logic skip_rx;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, got, exp, edge_cnt);
        end
    endtask

    function automatic logic exp_tx_bit(input int e);
        int d;
        int k;
        if (m_e0 < 0) return 1'b1;
        d = e - m_e0;
        if (d >= 10 * c_bit) return 1'b1;
        k = d / c_bit;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_tx_data[k-1];
    endfunction

    always @(posedge clk_i) begin
        edge_cnt++;
        e_chk = edge_cnt;
        if (rst_i) begin
            m_e0       = -1;
            m_busy_end = -1;
            m_rdy_rx   = 1'b0;
            m_data     = 8'h00;
            m_last_ev  = -1000;
            ev_edge.delete();
            ev_set.delete();
            ev_dat.delete();
        end else begin
            if (start_i && e_chk > m_busy_end) begin
                m_e0       = e_chk;
                m_busy_end = e_chk + 10 * c_bit;
                m_tx_data  = data_i;
            end
            while (ev_edge.size() > 0 && ev_edge[0] <= e_chk) begin
                if (ev_set[0]) begin
                    m_rdy_rx = 1'b1;
                    m_data   = ev_dat[0];
                end else begin
                    m_rdy_rx = 1'b0;
                end
                m_last_ev = ev_edge[0];
                void'(ev_edge.pop_front());
                void'(ev_set.pop_front());
                void'(ev_dat.pop_front());
            end
        end
        #1;
        if (!rst_i) begin
            check("tx_o", {31'b0, tx_o}, {31'b0, exp_tx_bit(e_chk)});
            check("rdy_tx_o", {31'b0, rdy_tx_o}, {31'b0, (e_chk >= m_busy_end)});
            skip_rx = (e_chk - m_last_ev <= c_tol) ||
                      (ev_edge.size() > 0 && ev_edge[0] - e_chk <= c_tol);
            if (!skip_rx) begin
                check("rdy_rx_o", {31'b0, rdy_rx_o}, {31'b0, m_rdy_rx});
                check("data_o", {24'b0, data_o}, {24'b0, m_data});
            end
        end
    end

    // Drive one frame on rx_i; stop_bit=0 makes a framing error
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        logic [9:0] bits;
        int s;
        bits = {stop_bit, d, 1'b0};
        @(negedge clk_i);
        rx_i = 1'b0;
        s = edge_cnt + 1;
        ev_edge.push_back(s + 2 + c_half);
        ev_set.push_back(1'b0);
        ev_dat.push_back(8'h00);
        if (stop_bit) begin
            ev_edge.push_back(s + 2 + c_half + 9 * c_bit);
            ev_set.push_back(1'b1);
            ev_dat.push_back(d);
        end
        repeat (c_bit - 1) @(negedge clk_i);
        for (int i = 1; i < 10; i++) begin
            @(negedge clk_i);
            rx_i = bits[i];
            repeat (c_bit - 1) @(negedge clk_i);
        end
        @(negedge clk_i);
        rx_i = 1'b1;
    endtask

    task automatic pulse_start(input logic [7:0] d);
        @(negedge clk_i);
        data_i  = d;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    initial begin
        #(60000 * 8);
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] tx_pat;
        tx_pat = 10'b1010101010;

        rst_i = 1'b1;
        repeat (10) @(negedge clk_i);
        check("reset_tx_o", {31'b0, tx_o}, 32'd1);
        check("reset_rdy_tx", {31'b0, rdy_tx_o}, 32'd1);
        check("reset_rdy_rx", {31'b0, rdy_rx_o}, 32'd0);
        check("reset_data_o", {24'b0, data_o}, 32'h00);
        rst_i = 1'b0;
        repeat (5) @(negedge clk_i);

        // TX 0x55: mid-bit samples of the frame, then ready return
        pulse_start(8'h55);
        data_i = 8'hAA;
        check("tx55_busy", {31'b0, rdy_tx_o}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            repeat ((k == 0) ? c_half : c_bit) @(negedge clk_i);
            check("tx55_bit", {31'b0, tx_o}, {31'b0, tx_pat[k]});
        end
        repeat (c_half) @(negedge clk_i);
        check("tx55_ready", {31'b0, rdy_tx_o}, 32'd1);

        // RX 0x53
        repeat (10) @(negedge clk_i);
        send_frame(8'h53, 1'b1);
        repeat (c_bit) @(negedge clk_i);
        check("rx53_data", {24'b0, data_o}, 32'h53);
        check("rx53_rdy", {31'b0, rdy_rx_o}, 32'd1);

        // Short low pulse must not start a frame
        @(negedge clk_i);
        rx_i = 1'b0;
        repeat (6) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (2 * c_bit) @(negedge clk_i);
        check("glitch_data", {24'b0, data_o}, 32'h53);
        check("glitch_rdy", {31'b0, rdy_rx_o}, 32'd1);

        // Framing error then a good frame
        send_frame(8'hA5, 1'b0);
        repeat (c_bit) @(negedge clk_i);
        check("ferr_rdy", {31'b0, rdy_rx_o}, 32'd0);
        check("ferr_data", {24'b0, data_o}, 32'h53);
        send_frame(8'h3C, 1'b1);
        repeat (c_bit) @(negedge clk_i);
        check("rx3c_data", {24'b0, data_o}, 32'h3C);
        check("rx3c_rdy", {31'b0, rdy_rx_o}, 32'd1);

        // Duplex with a start request while busy
        fork
            begin
                pulse_start(8'h55);
                repeat (100) @(negedge clk_i);
                pulse_start(8'hFF);
                for (int n = 0; n < 12 * c_bit && !rdy_tx_o; n++) @(negedge clk_i);
                check("duplex_tx_ready", {31'b0, rdy_tx_o}, 32'd1);
                pulse_start(8'h0F);
                check("duplex_next_accept", {31'b0, rdy_tx_o}, 32'd0);
            end
            begin
                repeat (20) @(negedge clk_i);
                send_frame(8'h53, 1'b1);
            end
        join
        repeat (11 * c_bit) @(negedge clk_i);
        check("duplex_rx_data", {24'b0, data_o}, 32'h53);

        // Randomized duplex traffic
        fork
            begin
                for (int i = 0; i < 3600; i++) begin
                    @(negedge clk_i);
                    start_i = ($urandom_range(0, 15) == 0);
                    data_i  = 8'($urandom);
                end
                start_i = 1'b0;
            end
            begin
                repeat (8) begin
                    send_frame(8'($urandom), ($urandom_range(0, 5) != 0));
                    repeat ($urandom_range(c_bit, 3 * c_bit)) @(negedge clk_i);
                end
            end
        join
        repeat (11 * c_bit) @(negedge clk_i);

        // Reset in the middle of a frame acts immediately
        pulse_start(8'h00);
        repeat (3 * c_bit) @(negedge clk_i);
        check("pre_reset_tx", {31'b0, tx_o}, 32'd0);
        rst_i = 1'b1;
        #1;
        check("async_reset_tx", {31'b0, tx_o}, 32'd1);
        check("async_reset_rdy_tx", {31'b0, rdy_tx_o}, 32'd1);
        check("async_reset_data", {24'b0, data_o}, 32'h00);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2 * c_bit) @(negedge clk_i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
